// File: rtl/y86_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | y86_pkg : shared Y86-64 icode constants and core status encoding   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        ERROR  = 2'd2
    } core_state_e;

endpackage : y86_pkg
`default_nettype wire

// File: rtl/ret_addr_stack.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ret_addr_stack : circular return-address stack, oldest entry lost  |
// | on overflow, underflow reported as a one-cycle pulse. Rev 1.0      |
// +--------------------------------------------------------------------+
module ret_addr_stack #(
    parameter int ADDR_W    = 64,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_data,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_underflow;
    logic [PTR_W-1:0]  w_top_idx;
    logic              w_empty;

    assign w_top_idx = r_ptr - PTR_W'(1);
    assign w_empty   = (r_count == '0);

    // Storage needs no reset; r_count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= pop && w_empty;
            if (push) begin
                r_ptr <= r_ptr + PTR_W'(1);
                if (r_count != C_FULL) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (pop && !w_empty) begin
                r_ptr   <= w_top_idx;
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign top       = w_empty ? '0 : r_mem[w_top_idx];
    assign count     = r_count;
    assign underflow = r_underflow;

endmodule : ret_addr_stack
`default_nettype wire

// File: rtl/pc_update_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_update_seq : registered Y86-64 PC update with run/halt/error    |
// | status and return-address prediction check. Rev 1.0               |
// +--------------------------------------------------------------------+
module pc_update_seq
    import y86_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         stall,
    input  logic [3:0]                   icode,
    input  logic                         cnd,
    input  logic [ADDR_W-1:0]            valC,
    input  logic [ADDR_W-1:0]            valM,
    input  logic [ADDR_W-1:0]            valP,
    output logic [ADDR_W-1:0]            pc,
    output logic                         halted,
    output logic                         error,
    output logic [ADDR_W-1:0]            ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ret_mismatch,
    output logic                         ras_underflow
);

    core_state_e       r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_halted;
    logic              r_error;
    logic              r_mismatch;

    logic              w_update;
    logic              w_illegal;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_next_pc;

    assign w_update  = (r_state == RUN) && in_valid && !stall;
    assign w_illegal = (icode > IPOPQ);
    assign w_push    = w_update && (icode == ICALL);
    assign w_pop     = w_update && (icode == IRET);

    always_comb begin
        w_next_pc = valP;
        if ((icode == ICALL) || ((icode == IJXX) && cnd)) begin
            w_next_pc = valC;
        end else if (icode == IRET) begin
            w_next_pc = valM;
        end else if (icode == IHALT) begin
            w_next_pc = r_pc;
        end
    end

    ret_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (valP),
        .top       (ras_top),
        .count     (ras_count),
        .underflow (ras_underflow)
    );

    // ras_top is the entry being popped in the same cycle as the ret.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_halted   <= 1'b0;
            r_error    <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= w_pop && (ras_count != '0) && (ras_top != valM);
            if (w_update) begin
                if (w_illegal) begin
                    r_state <= ERROR;
                    r_error <= 1'b1;
                end else if (icode == IHALT) begin
                    r_state  <= HALTED;
                    r_halted <= 1'b1;
                end else begin
                    r_pc <= w_next_pc;
                end
            end
        end
    end

    assign pc           = r_pc;
    assign halted       = r_halted;
    assign error        = r_error;
    assign ret_mismatch = r_mismatch;

endmodule : pc_update_seq
`default_nettype wire

// File: tb/tb_pc_update_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pc_update_seq : directed vectors with queued expectations       |
// | checked by an independent monitor. Rev 1.0                         |
// +--------------------------------------------------------------------+
module tb_pc_update_seq;

    typedef struct {
        logic [63:0] pc;
        logic        h;
        logic        e;
        logic [63:0] top;
        int          cnt;
        logic        mm;
        logic        uf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic        cnd = 1'b0;
    logic [63:0] valC = '0;
    logic [63:0] valM = '0;
    logic [63:0] valP = '0;
    logic [63:0] pc;
    logic        halted;
    logic        error;
    logic [63:0] ras_top;
    logic [3:0]  ras_count;
    logic        ret_mismatch;
    logic        ras_underflow;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    pc_update_seq #(
        .ADDR_W    (64),
        .RAS_DEPTH (8),
        .RESET_PC  (64'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .stall         (stall),
        .icode         (icode),
        .cnd           (cnd),
        .valC          (valC),
        .valM          (valM),
        .valP          (valP),
        .pc            (pc),
        .halted        (halted),
        .error         (error),
        .ras_top       (ras_top),
        .ras_count     (ras_count),
        .ret_mismatch  (ret_mismatch),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, req);
    endtask

    // Drive one cycle of inputs and queue the state expected after that edge.
    task automatic cyc(input logic r, input logic v, input logic s, input logic [3:0] ic,
                       input logic c, input logic [63:0] vc, input logic [63:0] vm,
                       input logic [63:0] vp, input logic [63:0] e_pc, input logic e_h,
                       input logic e_e, input logic [63:0] e_top, input int e_cnt,
                       input logic e_mm, input logic e_uf);
        exp_t x;
        @(negedge clk);
        rst = r; in_valid = v; stall = s; icode = ic; cnd = c;
        valC = vc; valM = vm; valP = vp;
        @(posedge clk);
        x.pc = e_pc; x.h = e_h; x.e = e_e; x.top = e_top; x.cnt = e_cnt;
        x.mm = e_mm; x.uf = e_uf;
        exp_q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("pc", pc, x.pc);
                chk("halted", {63'd0, halted}, {63'd0, x.h});
                chk("error", {63'd0, error}, {63'd0, x.e});
                chk("ras_top", ras_top, x.top);
                chk("ras_count", {60'd0, ras_count}, 64'(x.cnt));
                chk("ret_mismatch", {63'd0, ret_mismatch}, {63'd0, x.mm});
                chk("ras_underflow", {63'd0, ras_underflow}, {63'd0, x.uf});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // reset and idle
        cyc(1,0,0,4'h1,0, 0,0,0,  0,0,0, 0,0,0,0);
        cyc(1,0,0,4'h1,0, 0,0,0,  0,0,0, 0,0,0,0);
        for (int i = 0; i < 5; i++) cyc(0,0,0,4'h8,0, 64'h500,0,64'h9, 0,0,0, 0,0,0,0);

        // jumps and plain sequencing
        cyc(0,1,0,4'h7,0, 64'h40,0,64'h0A,  64'h0A,0,0, 0,0,0,0);
        cyc(0,1,0,4'h7,1, 64'h40,0,64'h0C,  64'h40,0,0, 0,0,0,0);
        cyc(0,1,0,4'h6,0, 0,0,64'h42,       64'h42,0,0, 0,0,0,0);

        // call / matching ret / underflowing ret
        cyc(0,1,0,4'h8,0, 64'h100,0,64'h2A, 64'h100,0,0, 64'h2A,1,0,0);
        cyc(0,1,0,4'h9,0, 0,64'h2A,64'h5,   64'h2A,0,0, 0,0,0,0);
        cyc(0,1,0,4'h9,0, 0,64'h55,64'h5,   64'h55,0,0, 0,0,0,1);
        cyc(0,0,0,4'h1,0, 0,0,0,            64'h55,0,0, 0,0,0,0);

        // overflow wrap: 9 calls then 8 matching rets
        for (int i = 1; i <= 9; i++)
            cyc(0,1,0,4'h8,0, 64'h200+64'(i),0,64'(i),
                64'h200+64'(i),0,0, 64'(i),(i > 8) ? 8 : i,0,0);
        for (int k = 0; k < 8; k++)
            cyc(0,1,0,4'h9,0, 0,64'(9-k),0,
                64'(9-k),0,0, (k < 7) ? 64'(8-k) : 64'h0, 7-k,0,0);

        // mispredicted return
        cyc(0,1,0,4'h8,0, 64'h300,0,64'h77, 64'h300,0,0, 64'h77,1,0,0);
        cyc(0,1,0,4'h9,0, 0,64'h78,0,       64'h78,0,0, 0,0,1,0);
        cyc(0,0,0,4'h1,0, 0,0,0,            64'h78,0,0, 0,0,0,0);

        // stall holds everything
        for (int i = 0; i < 3; i++) cyc(0,1,1,4'h8,0, 64'h500,0,64'h99, 64'h78,0,0, 0,0,0,0);

        // halt freezes pc and RAS until reset
        cyc(0,1,0,4'h8,0, 64'h600,0,64'h61, 64'h600,0,0, 64'h61,1,0,0);
        cyc(0,1,0,4'h0,0, 0,0,64'h999,      64'h600,1,0, 64'h61,1,0,0);
        cyc(0,1,0,4'h8,0, 64'h700,0,64'h71, 64'h600,1,0, 64'h61,1,0,0);
        cyc(0,1,0,4'h9,0, 0,64'h61,0,       64'h600,1,0, 64'h61,1,0,0);
        cyc(1,1,0,4'h8,0, 64'h700,0,64'h71, 0,0,0, 0,0,0,0);

        // illegal icode -> error, absorbing; reset wins over stall
        cyc(0,1,0,4'hC,0, 64'h800,0,64'h10, 0,0,1, 0,0,0,0);
        cyc(0,1,0,4'h8,0, 64'h800,0,64'h10, 0,0,1, 0,0,0,0);
        cyc(0,1,0,4'h9,0, 0,64'h33,0,       0,0,1, 0,0,0,0);
        cyc(1,1,1,4'h8,0, 64'h800,0,64'h10, 0,0,0, 0,0,0,0);
        cyc(0,1,0,4'h8,0, 64'h900,0,64'h20, 64'h900,0,0, 64'h20,1,0,0);

        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; stall = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pc_update_seq
`default_nettype wire

// File: doc/pc_update_seq.md
Name: pc_update_seq

Overview:
- Clocked successor to the combinational next-PC selector of the Y86-64 core.
- Holds the architectural PC register and selects the next PC from icode, Cnd, valC, valM and valP.
- Tracks run/halt/error status.
- Keeps a parametrised circular return-address stack (RAS): pushes valP on call, pops on ret, and flags a mismatch when the popped address differs from valM.
- Sits between the execute/memory stages and fetch; its pc output drives the fetch module.

Parameters:
- ADDR_W, 64, width of PC, valC, valM and valP.
- RAS_DEPTH, 8, number of RAS entries; power of two, at least 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the current icode/Cnd/val* describe a completed instruction.
- stall  in  1  hold all state this cycle; overrides in_valid.
- icode  in  4  instruction code of the completed instruction.
- cnd  in  1  condition result for jXX.
- valC  in  ADDR_W  constant / target field.
- valM  in  ADDR_W  value read from memory (return address for ret).
- valP  in  ADDR_W  address of the sequentially next instruction.
- pc  out  ADDR_W  registered PC presented to fetch.
- halted  out  1  core is in the HALTED state.
- error  out  1  core is in the ERROR state.
- ras_top  out  ADDR_W  current top-of-stack entry; 0 when empty.
- ras_count  out  clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ret_mismatch  out  1  one-cycle pulse: a ret popped an address that differs from valM.
- ras_underflow  out  1  one-cycle pulse: a ret arrived with the RAS empty.

Behaviour:
- Reset (rst=1 at posedge; wins over every other input):
  - pc=RESET_PC, state=RUN.
  - ras_count=0, RAS pointer=0.
  - ret_mismatch=0, ras_underflow=0, halted=0, error=0.
  - RAS storage contents need not be cleared.
- Update event: posedge with state==RUN, in_valid=1 and stall=0. No other posedge changes pc, state or the RAS.
- Next-PC rule, registered with 1-cycle latency from the update event:
  - icode 8 (call), or icode 7 (jXX) with cnd=1 -> valC.
  - icode 9 (ret) -> valM.
  - icode 0 (halt) -> pc unchanged.
  - anything else -> valP.
- State machine: RUN, HALTED, ERROR.
  - RUN -> HALTED on an update event with icode 0.
  - RUN -> ERROR on an update event with icode > 4'hB; pc is unchanged on that event.
  - HALTED and ERROR are absorbing: only rst leaves them. pc and RAS stay frozen in both.
- RAS push (call update event):
  - Write valP at the pointer, then pointer+1 mod RAS_DEPTH.
  - ras_count saturates at RAS_DEPTH.
  - Pushing while full silently overwrites the oldest entry.
- RAS pop (ret update event, ras_count>0):
  - Pointer-1 mod RAS_DEPTH; ras_count-1.
  - ret_mismatch=1 next cycle if the popped entry != valM.
- RAS pop when empty:
  - ras_underflow=1 next cycle; pointer and count unchanged; no mismatch check.
  - pc still takes valM.
- Pulse outputs stay high for exactly one cycle and clear on the next posedge unless re-triggered.
- ras_top is combinational from storage[pointer-1] when ras_count>0, otherwise 0.
- Only one icode arrives per cycle, so push and pop never coincide.
- Width rules: all address arithmetic is ADDR_W bits, no sign extension. Pointer wrap is modulo RAS_DEPTH.
- Stall held across multiple cycles: state fully frozen; inputs are sampled only on the first non-stalled valid cycle.

Decomposition:
- Shared package y86_pkg:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B.
  - State enum: RUN, HALTED, ERROR.
- One natural sub-module, ret_addr_stack: circular buffer with push/pop/top/count/underflow, parametrised by ADDR_W and RAS_DEPTH.
- The top level keeps the PC register, next-PC mux, state machine and mismatch compare.

Test Plan:
- Reset, then idle with in_valid=0 -> pc=RESET_PC, ras_count=0, halted=0, error=0 for 5 cycles.
- Update events: icode 7, cnd=0, valP=0x0A, valC=0x40 -> pc=0x0A; then icode 7, cnd=1, valC=0x40 -> pc=0x40; then icode 6, valP=0x42 -> pc=0x42.
- call valC=0x100, valP=0x2A -> pc=0x100, ras_top=0x2A, ras_count=1; then ret valM=0x2A -> pc=0x2A, ras_count=0, ret_mismatch=0; then ret valM=0x55 -> pc=0x55, ras_underflow pulses for 1 cycle.
- RAS_DEPTH=8: 9 calls with valP=1..9, then 8 rets with matching valM=9..2 -> no mismatch, ras_count=0. Then call valP=0x77 and ret valM=0x78 -> ret_mismatch=1 for one cycle.
- stall=1 for 3 cycles with in_valid=1, icode 8 -> pc and RAS unchanged. icode 0 update -> halted=1 and pc frozen despite further valid calls; rst -> pc=RESET_PC, halted=0.
- icode 0xC update event -> error=1, pc unchanged; further updates are ignored until rst; rst asserted mid-stall -> reset wins.
